input_conditioner: RTL and testbench
====================================

# input_conditioner

Conditions the raw DE1-SoC slider-switch and pushbutton pins before they reach the Qsys system's `slider_switches_export` and `pushbuttons_export` PIO inputs. Each pin is synchronised, debounced, polarity-normalised and edge-detected. The block also exposes per-key press/release pulses and a sticky edge-capture register for FPGA-side logic. It sits in the top level, between the board pins and the `CPEN391_Computer` instance.

## Interface
- `SW_WIDTH`, default 10: number of slider switches.
- `KEY_WIDTH`, default 4: number of pushbuttons.
- `DEBOUNCE_CYCLES`, default 1000000: consecutive cycles a new level must persist. 20 ms at 50 MHz. Legal range is 1 or more.
- `KEY_ACTIVE_LOW`, default 1: raw keys read 0 when pressed.
- `clk_clk`  in  1: the single clock, 50 MHz system clock.
- `reset_reset`  in  1: asynchronous, active-high reset.
- `sw_raw`  in  SW_WIDTH: switch pins, asynchronous to `clk_clk`.
- `key_raw`  in  KEY_WIDTH: pushbutton pins, asynchronous.
- `slider_switches_export`  out  SW_WIDTH: debounced switch levels (1 = up).
- `pushbuttons_export`  out  KEY_WIDTH: debounced key levels (1 = pressed, always active-high).
- `sw_change_pulse`  out  SW_WIDTH: 1-cycle pulse when a debounced switch changes.
- `key_press_pulse`  out  KEY_WIDTH: 1-cycle pulse when a debounced key becomes pressed.
- `key_release_pulse`  out  KEY_WIDTH: 1-cycle pulse when a debounced key becomes released.
- `key_edge_capture`  out  KEY_WIDTH: sticky per-key press flag.
- `key_edge_clear`  in  KEY_WIDTH: write-1-to-clear for `key_edge_capture`, per bit.

## Operation
- **Normalisation.** When `KEY_ACTIVE_LOW`=1, key bits are inverted before synchronisation. From then on, everything internal is active-high "pressed".
- **Synchronisation.** Every bit passes through a 2-flop synchroniser, `s1` then `s2`.
- **Debounce, per bit, independently.**
  - Each bit has a debounced level `stable` and a counter `cnt` of width clog2(DEBOUNCE_CYCLES+1).
  - If `s2` == `stable`: `cnt` <= 0.
  - If `s2` != `stable` and `cnt` < DEBOUNCE_CYCLES-1: `cnt` <= `cnt`+1.
  - If `s2` != `stable` and `cnt` == DEBOUNCE_CYCLES-1: `stable` <= `s2`, `cnt` <= 0, and the corresponding pulse is asserted in the same cycle `stable` changes.
  - A glitch shorter than DEBOUNCE_CYCLES cycles (measured at `s2`) never reaches `stable`. Any return to the old level restarts the count from 0.
  - The counter never wraps. It saturates by the rule above.
- **Pulses.** All pulses are registered and high for exactly 1 cycle.
  - `sw_change_pulse` fires on both directions of a switch change.
  - `key_press_pulse` fires on a 0→1 `stable` change; `key_release_pulse` fires on a 1→0 change.
- **Edge capture.** Next state per bit = (capture & ~`key_edge_clear`) | `key_press_pulse`.
  - When a clear and a new press land in the same cycle, the press wins and the bit stays 1.
  - A clear of an already-0 bit has no effect.
- **Outputs.** All outputs come straight from flops; there is no combinational path from input to output.
- **Reset** (asynchronous, any time, including mid-debounce):
  - Synchroniser flops, `stable`, `cnt`, all pulses and `key_edge_capture` go to 0. For keys, 0 means released.
  - After release, inputs held at 1 are treated as new changes. For example, a switch held up produces `sw_change_pulse` and `slider_switches_export`=1 after the normal latency. A key held through reset produces a press pulse.

## Timing
- **Latency.** For a clean raw change that stays constant, the debounced output and its pulse change on the (DEBOUNCE_CYCLES+2)-th rising edge after the first edge that samples the new raw level: 2 cycles of synchroniser plus DEBOUNCE_CYCLES of count.
- **Edge capture.** `key_edge_capture` sets in the cycle after `key_press_pulse`. It clears in the cycle after `key_edge_clear` is sampled high.
- **Throughput.** The minimum spacing between debounced transitions on one bit is DEBOUNCE_CYCLES cycles.
- **Independence.** Bits are fully independent; simultaneous changes on several bits produce simultaneous pulses.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and KEY_ACTIVE_LOW=1.
- **Reset values.** Assert `reset_reset` with `sw_raw`=0 and `key_raw`=4'hF → every output is 0. Assert it mid-count → `cnt` clears and no pulse appears.
- **Clean switch.** `sw_raw[3]` goes 0→1 at edge 0 → `slider_switches_export[3]`=1 and a single-cycle `sw_change_pulse[3]` at edge 6. Returning to 0 → the pulse repeats and the output goes to 0 after 6 edges.
- **Bounce rejection.** `key_raw[0]`=0 for 3 cycles, 1 for 1 cycle, then 0 steady → no pulse during the bounce. `pushbuttons_export[0]`=1 and `key_press_pulse[0]` fire 6 edges after the final falling edge.
- **Release.** Release key 0 → `key_release_pulse[0]` for 1 cycle and `pushbuttons_export[0]`=0. `key_edge_capture[0]` stays 1.
- **Edge capture clear/set race.** `key_edge_clear[1]`=1 in the same cycle as `key_press_pulse[1]` → `key_edge_capture[1]`=1. A later clear with no press → 0.
- **Held through reset.** Hold `key_raw[2]`=0 and `sw_raw[9]`=1 across a reset pulse → 6 edges after deassertion, `key_press_pulse[2]` and `sw_change_pulse[9]` fire together, and both exports read 1.

Source files
------------

// File: rtl/input_conditioner.sv
// Board-pin conditioner for slider switches and pushbuttons: 2-flop sync, per-bit
// debounce, key polarity normalisation, change/press/release pulses and sticky key capture.
module input_conditioner #(
    parameter int SW_WIDTH        = 10,
    parameter int KEY_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [SW_WIDTH-1:0]  sw_raw,
    input  logic [KEY_WIDTH-1:0] key_raw,
    output logic [SW_WIDTH-1:0]  slider_switches_export,
    output logic [KEY_WIDTH-1:0] pushbuttons_export,
    output logic [SW_WIDTH-1:0]  sw_change_pulse,
    output logic [KEY_WIDTH-1:0] key_press_pulse,
    output logic [KEY_WIDTH-1:0] key_release_pulse,
    output logic [KEY_WIDTH-1:0] key_edge_capture,
    input  logic [KEY_WIDTH-1:0] key_edge_clear
);

    localparam int unsigned N  = SW_WIDTH + KEY_WIDTH;
    localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]         raw_norm;
    logic [N-1:0]         s1_q, s2_q;
    logic [N-1:0]         stable_q, stable_d;
    logic [N-1:0]         rise_q, rise_d;
    logic [N-1:0]         fall_q, fall_d;
    logic [CW-1:0]        cnt_q [N];
    logic [CW-1:0]        cnt_d [N];
    logic [KEY_WIDTH-1:0] cap_q, cap_d;

    // Keys are flipped ahead of the synchroniser so every internal bit reads 1 = pressed/up.
    assign raw_norm = {((KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw), sw_raw};

    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s2_q[i];
                    rise_d[i]   = s2_q[i];
                    fall_d[i]   = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A press in the same cycle as a clear leaves the bit set.
    assign cap_d = (cap_q & ~key_edge_clear) | rise_q[N-1:SW_WIDTH];

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            cap_q    <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= raw_norm;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cap_q    <= cap_d;
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign slider_switches_export = stable_q[SW_WIDTH-1:0];
    assign pushbuttons_export     = stable_q[N-1:SW_WIDTH];
    assign sw_change_pulse        = rise_q[SW_WIDTH-1:0] | fall_q[SW_WIDTH-1:0];
    assign key_press_pulse        = rise_q[N-1:SW_WIDTH];
    assign key_release_pulse      = fall_q[N-1:SW_WIDTH];
    assign key_edge_capture       = cap_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4 and active-low keys.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sw_raw;
    logic [3:0] key_raw;
    logic [3:0] key_edge_clear;
    logic [9:0] sw_exp_o, sw_pulse_o;
    logic [3:0] key_exp_o, press_o, release_o, cap_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] seen;

    input_conditioner #(
        .SW_WIDTH(10),
        .KEY_WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .KEY_ACTIVE_LOW(1)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .sw_raw(sw_raw),
        .key_raw(key_raw),
        .slider_switches_export(sw_exp_o),
        .pushbuttons_export(key_exp_o),
        .sw_change_pulse(sw_pulse_o),
        .key_press_pulse(press_o),
        .key_release_pulse(release_o),
        .key_edge_capture(cap_o),
        .key_edge_clear(key_edge_clear)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sw_exp"},  32'(sw_exp_o),   32'h0);
        chk({tag, "_key_exp"}, 32'(key_exp_o),  32'h0);
        chk({tag, "_swpulse"}, 32'(sw_pulse_o), 32'h0);
        chk({tag, "_press"},   32'(press_o),    32'h0);
        chk({tag, "_release"}, 32'(release_o),  32'h0);
        chk({tag, "_cap"},     32'(cap_o),      32'h0);
    endtask

    initial begin
        rst = 1'b1; sw_raw = '0; key_raw = 4'hF; key_edge_clear = '0;
        step(3);
        chk_all_zero("reset");
        rst = 1'b0;
        step(8);
        chk_all_zero("idle");

        // Clean switch rise: driven after edge 0, visible at edge 6.
        sw_raw[3] = 1'b1;
        step(5);
        chk("sw_rise_e5_exp",   32'(sw_exp_o),   32'h000);
        chk("sw_rise_e5_pulse", 32'(sw_pulse_o), 32'h000);
        step(1);
        chk("sw_rise_e6_exp",   32'(sw_exp_o),   32'h008);
        chk("sw_rise_e6_pulse", 32'(sw_pulse_o), 32'h008);
        step(1);
        chk("sw_rise_e7_pulse", 32'(sw_pulse_o), 32'h000);
        chk("sw_rise_e7_exp",   32'(sw_exp_o),   32'h008);

        sw_raw[3] = 1'b0;
        step(5);
        chk("sw_fall_e5_exp",   32'(sw_exp_o),   32'h008);
        step(1);
        chk("sw_fall_e6_exp",   32'(sw_exp_o),   32'h000);
        chk("sw_fall_e6_pulse", 32'(sw_pulse_o), 32'h008);
        step(1);
        chk("sw_fall_e7_pulse", 32'(sw_pulse_o), 32'h000);

        // Bounce: 3 cycles pressed, 1 released, then pressed steady.
        seen = '0;
        key_raw = 4'hE;
        for (int k = 0; k < 3; k++) begin step(1); seen |= 32'(press_o | key_exp_o); end
        key_raw = 4'hF;
        step(1); seen |= 32'(press_o | key_exp_o);
        key_raw = 4'hE;
        for (int k = 0; k < 5; k++) begin step(1); seen |= 32'(press_o | key_exp_o); end
        chk("bounce_no_early", seen, 32'h0);
        step(1);
        chk("bounce_press",     32'(press_o),   32'h1);
        chk("bounce_key_exp",   32'(key_exp_o), 32'h1);
        chk("bounce_cap_early", 32'(cap_o),     32'h0);
        step(1);
        chk("bounce_press_end", 32'(press_o), 32'h0);
        chk("bounce_cap",       32'(cap_o),   32'h1);

        // Release of key 0.
        key_raw = 4'hF;
        step(5);
        chk("rel_e5_release", 32'(release_o), 32'h0);
        step(1);
        chk("rel_release", 32'(release_o), 32'h1);
        chk("rel_key_exp", 32'(key_exp_o), 32'h0);
        chk("rel_cap",     32'(cap_o),     32'h1);
        step(1);
        chk("rel_release_end", 32'(release_o), 32'h0);

        // Clear racing a press on key 1.
        key_raw = 4'hD;
        step(6);
        chk("race_press", 32'(press_o), 32'h2);
        key_edge_clear = 4'h2;
        step(1);
        key_edge_clear = 4'h0;
        chk("race_cap_kept", 32'(cap_o), 32'h3);
        key_edge_clear = 4'h2;
        step(1);
        key_edge_clear = 4'h0;
        chk("clear_cap", 32'(cap_o), 32'h1);
        key_edge_clear = 4'h4;
        step(1);
        key_edge_clear = 4'h0;
        chk("clear_zero_bit", 32'(cap_o), 32'h1);
        key_raw = 4'hF;
        step(6);
        chk("race_release", 32'(release_o), 32'h2);
        step(2);

        // Reset in the middle of a count: nothing may emerge afterwards.
        sw_raw[0] = 1'b1;
        step(3);
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        sw_raw[0] = 1'b0;
        step(2);
        rst = 1'b0;
        seen = '0;
        for (int k = 0; k < 10; k++) begin step(1); seen |= 32'(sw_pulse_o | sw_exp_o); end
        chk("midreset_quiet", seen, 32'h0);

        // Levels held through reset appear as fresh changes.
        rst = 1'b1;
        key_raw = 4'hB;
        sw_raw = 10'h200;
        step(2);
        chk("held_in_reset_key", 32'(key_exp_o), 32'h0);
        chk("held_in_reset_sw",  32'(sw_exp_o),  32'h0);
        rst = 1'b0;
        step(5);
        chk("held_e5_press", 32'(press_o),    32'h0);
        chk("held_e5_sw",    32'(sw_pulse_o), 32'h000);
        step(1);
        chk("held_press",   32'(press_o),    32'h4);
        chk("held_swpulse", 32'(sw_pulse_o), 32'h200);
        chk("held_key_exp", 32'(key_exp_o),  32'h4);
        chk("held_sw_exp",  32'(sw_exp_o),   32'h200);
        step(1);
        chk("held_press_end", 32'(press_o),    32'h0);
        chk("held_sw_end",    32'(sw_pulse_o), 32'h000);
        chk("held_cap",       32'(cap_o),      32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
